// File: rtl/spi_tx_fifo_slave.sv
// SPI slave transmitter fed by a FIFO of Kalman filter results.
// Runs entirely on clk, oversampling rpi_sck/rpi_cs; supports all four SPI modes.
module spi_tx_fifo_slave #(
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    FIFO_DEPTH    = 4,
  parameter bit                    CPOL          = 1'b0,
  parameter bit                    CPHA          = 1'b0,
  parameter bit                    MSB_FIRST     = 1'b1,
  parameter bit                    IDLE_LEVEL    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] UNDERRUN_WORD = '1,
  parameter int                    SYNC_STAGES   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_WIDTH-1:0]       filtered_data,
  input  logic                        filter_done,
  input  logic                        clear_flags,
  input  logic                        rpi_sck,
  input  logic                        rpi_cs,
  output logic                        rpi_miso,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        underrun,
  output logic                        frame_done,
  output logic                        frame_abort,
  output logic [1:0]                  fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_next;

  // ---------------- synchronisers and edge detection ----------------
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync;
  logic                   sck_d, cs_d;
  logic [SYNC_STAGES:0]   warm;
  logic                   sck_s, cs_s, ready;
  logic                   lead_q, trail_q, cs_fall_q, cs_rise_q;

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign cs_s  = cs_sync[SYNC_STAGES-1];
  // Edges are ignored until real pin samples have filled the chain, so cs held
  // low across reset release cannot masquerade as a falling edge.
  assign ready = warm[SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '1;
      sck_d     <= CPOL;
      cs_d      <= 1'b1;
      warm      <= '0;
      lead_q    <= 1'b0;
      trail_q   <= 1'b0;
      cs_fall_q <= 1'b0;
      cs_rise_q <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], rpi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], rpi_cs};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
      warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
      lead_q    <= ready && (sck_s != CPOL) && (sck_d == CPOL);
      trail_q   <= ready && (sck_s == CPOL) && (sck_d != CPOL);
      cs_fall_q <= ready && !cs_s && cs_d;
      cs_rise_q <= ready && cs_s && !cs_d;
    end
  end

  // ---------------- FIFO ----------------
  // filter_done is a valid-only strobe with no ready: a push into a full FIFO
  // is dropped and flagged, unless a pop frees a slot in the same cycle.
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  full, empty, load, pop, push_ok;

  assign full    = (fifo_count == (AW + 1)'(FIFO_DEPTH));
  assign empty   = (fifo_count == '0);
  assign pop     = load && !empty;
  assign push_ok = filter_done && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= filtered_data;
  end

  // ---------------- FSM ----------------
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]         bit_cnt;
  logic                  miso_r, out_bit;
  logic                  advance, present, cnt_inc, done_set, abort_set;

  assign out_bit    = MSB_FIRST ? shift_reg[DATA_WIDTH-1] : shift_reg[0];
  assign shift_next = MSB_FIRST ? {shift_reg[DATA_WIDTH-2:0], 1'b0}
                                : {1'b0, shift_reg[DATA_WIDTH-1:1]};
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    present    = 1'b0;
    cnt_inc    = 1'b0;
    done_set   = 1'b0;
    abort_set  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall_q) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise_q) begin
          abort_set  = 1'b1;
          state_next = IDLE;
        end else begin
          if (CPHA) present = lead_q;
          else      advance = trail_q;
          cnt_inc = trail_q;
          if (trail_q && bit_cnt == CW'(DATA_WIDTH - 1)) begin
            done_set   = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (cs_rise_q) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      overflow    <= 1'b0;
      underrun    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      miso_r      <= IDLE_LEVEL;
    end else begin
      frame_done  <= done_set;
      frame_abort <= abort_set;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (filter_done && full && !pop) overflow <= 1'b1;
      else if (clear_flags)            overflow <= 1'b0;
      if (load && empty)               underrun <= 1'b1;
      else if (clear_flags)            underrun <= 1'b0;
      if (load) begin
        shift_reg <= empty ? UNDERRUN_WORD : mem[rd_ptr];
        bit_cnt   <= '0;
        miso_r    <= IDLE_LEVEL;
      end else begin
        if (advance || present) shift_reg <= shift_next;
        if (present)            miso_r    <= out_bit;
        if (cnt_inc)            bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

  // Combinational from state so reset forces the idle level without a clock.
  always_comb begin
    rpi_miso = IDLE_LEVEL;
    if (state == SHIFT) rpi_miso = CPHA ? miso_r : out_bit;
  end

endmodule

// File: tb/tb_spi_tx_fifo_slave.sv
// Bench for spi_tx_fifo_slave: a mode-0 MSB-first instance and a mode-3 LSB-first
// instance, driven by an SPI master task and checked against a queue-based model.
module tb_spi_tx_fifo_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] fdata;
  logic        fd0, fd1, clr;
  logic        sck0, sck1, cs0, cs1;
  logic        miso0, miso1;
  logic [2:0]  cnt0, cnt1;
  logic        ovf0, ovf1, und0, und1, done0, done1, abort0, abort1;
  logic [1:0]  st0, st1;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mq0[$], mq1[$];
  logic [15:0] exp_q0[$], exp_q1[$];
  bit          ovf_m[2], und_m[2];
  int          done_exp[2], abort_exp[2], done_seen[2], abort_seen[2];
  logic        rx_valid0, rx_valid1;
  logic [15:0] rx_word0, rx_word1;

  always #5 clk = ~clk;

  spi_tx_fifo_slave dut0 (
    .clk(clk), .rst_n(rst_n), .filtered_data(fdata), .filter_done(fd0),
    .clear_flags(clr), .rpi_sck(sck0), .rpi_cs(cs0), .rpi_miso(miso0),
    .fifo_count(cnt0), .overflow(ovf0), .underrun(und0), .frame_done(done0),
    .frame_abort(abort0), .fsm_state(st0)
  );

  spi_tx_fifo_slave #(.CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .filtered_data(fdata), .filter_done(fd1),
    .clear_flags(clr), .rpi_sck(sck1), .rpi_cs(cs1), .rpi_miso(miso1),
    .fifo_count(cnt1), .overflow(ovf1), .underrun(und1), .frame_done(done1),
    .frame_abort(abort1), .fsm_state(st1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int msize(input int inst);
    return (inst == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic model_push(input int inst, input logic [15:0] w);
    if (msize(inst) < 4) begin
      if (inst == 0) mq0.push_back(w); else mq1.push_back(w);
    end else ovf_m[inst] = 1'b1;
  endtask

  task automatic model_pop(input int inst, output logic [15:0] w);
    if (msize(inst) > 0) w = (inst == 0) ? mq0.pop_front() : mq1.pop_front();
    else begin
      w = 16'hFFFF;
      und_m[inst] = 1'b1;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_fd(input int inst, input logic v);
    if (inst == 0) fd0 = v; else fd1 = v;
  endtask

  task automatic set_cs(input int inst, input logic v);
    if (inst == 0) cs0 = v; else cs1 = v;
  endtask

  task automatic push(input int inst, input logic [15:0] w);
    @(posedge clk); #1;
    fdata = w;
    set_fd(inst, 1'b1);
    @(posedge clk); #1;
    set_fd(inst, 1'b0);
    model_push(inst, w);
  endtask

  task automatic clear_all();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    ovf_m[0] = 1'b0; ovf_m[1] = 1'b0; und_m[0] = 1'b0; und_m[1] = 1'b0;
  endtask

  task automatic check_flags(input int inst);
    check($sformatf("fifo_count%0d", inst), (inst == 0) ? cnt0 : cnt1, msize(inst));
    check($sformatf("overflow%0d", inst), (inst == 0) ? ovf0 : ovf1, ovf_m[inst]);
    check($sformatf("underrun%0d", inst), (inst == 0) ? und0 : und1, und_m[inst]);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // SPI master; both configured modes sample MISO on the rising sck edge.
  task automatic do_frame(input int inst, input int nbits, input bit push_at_pop,
                          input logic [15:0] pw);
    logic [15:0] w, rx;
    logic        b;
    @(posedge clk); #1;
    set_cs(inst, 1'b0);
    model_pop(inst, w);
    if (nbits == 16) begin
      if (inst == 0) exp_q0.push_back(w); else exp_q1.push_back(w);
    end
    if (push_at_pop) begin
      // cs falls after edge 0; the pop lands on edge 4.
      wait_clks(3);
      fdata = pw;
      set_fd(inst, 1'b1);
      wait_clks(1);
      set_fd(inst, 1'b0);
      model_push(inst, pw);
      wait_clks(4);
    end else wait_clks(8);
    if (inst == 1) check("cpha1_idle_before_lead", miso1, 1'b1);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      if (inst == 0) begin
        b = miso0; sck0 = 1'b1; wait_clks(6);
        sck0 = 1'b0; wait_clks(6);
        rx = {rx[14:0], b};
      end else begin
        sck1 = 1'b0; wait_clks(6);
        b = miso1; sck1 = 1'b1; wait_clks(6);
        rx = {b, rx[15:1]};
      end
    end
    if (nbits == 16) begin
      check($sformatf("miso_idle_done%0d", inst), (inst == 0) ? miso0 : miso1, 1'b1);
      done_exp[inst]++;
      if (inst == 0) begin rx_word0 = rx; rx_valid0 = 1'b1; end
      else           begin rx_word1 = rx; rx_valid1 = 1'b1; end
      wait_clks(1);
      rx_valid0 = 1'b0; rx_valid1 = 1'b0;
    end else abort_exp[inst]++;
    wait_clks(2);
    set_cs(inst, 1'b1);
    wait_clks(8);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rx_valid0) begin
      if (exp_q0.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL rx0: got 0x%0h, expected nothing queued", rx_word0);
      end else check("rx_word0", rx_word0, exp_q0.pop_front());
    end
    if (rx_valid1) begin
      if (exp_q1.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL rx1: got 0x%0h, expected nothing queued", rx_word1);
      end else check("rx_word1", rx_word1, exp_q1.pop_front());
    end
    if (done0)  done_seen[0]++;
    if (done1)  done_seen[1]++;
    if (abort0) abort_seen[0]++;
    if (abort1) abort_seen[1]++;
  end

  // ---------------- sequence ----------------
  initial begin
    int inst, np, nf, nb;
    fdata = '0; fd0 = 1'b0; fd1 = 1'b0; clr = 1'b0;
    sck0 = 1'b0; sck1 = 1'b1; cs0 = 1'b1; cs1 = 1'b1;
    rx_valid0 = 1'b0; rx_valid1 = 1'b0; rx_word0 = '0; rx_word1 = '0;
    #2;
    check("miso0_in_reset", miso0, 1'b1);
    check("miso1_in_reset", miso1, 1'b1);
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(5);
    check_flags(0);
    check_flags(1);
    check("frame_done_reset", done0, 1'b0);
    check("frame_abort_reset", abort0, 1'b0);

    // Basic mode-0 frame.
    push(0, 16'hA5C3);
    check_flags(0);
    do_frame(0, 16, 1'b0, '0);
    check_flags(0);

    // Overflow then drain, plus one underrun frame.
    push(0, 16'h1111); push(0, 16'h2222); push(0, 16'h3333);
    push(0, 16'h4444); push(0, 16'h5555);
    check_flags(0);
    for (int i = 0; i < 5; i++) do_frame(0, 16, 1'b0, '0);
    check_flags(0);
    clear_all();
    check_flags(0);

    // Mode 3, LSB first.
    push(1, 16'h0001);
    do_frame(1, 16, 1'b0, '0);
    check_flags(1);

    // Abort after 5 sck cycles, popped word is discarded.
    push(0, 16'hBEEF); push(0, 16'hCAFE);
    do_frame(0, 5, 1'b0, '0);
    check_flags(0);
    do_frame(0, 16, 1'b0, '0);
    check_flags(0);

    // Push coincident with the pop of a frame start while full.
    push(0, 16'h0A0A); push(0, 16'h0B0B); push(0, 16'h0C0C); push(0, 16'h0D0D);
    do_frame(0, 16, 1'b1, 16'h7777);
    check_flags(0);
    for (int i = 0; i < 4; i++) do_frame(0, 16, 1'b0, '0);
    check_flags(0);

    // Reset mid-frame with two words queued.
    clear_all();
    push(0, 16'h0000); push(0, 16'h1234);
    @(posedge clk); #1 cs0 = 1'b0;
    begin
      logic [15:0] lost;
      model_pop(0, lost);
    end
    wait_clks(8);
    for (int i = 0; i < 5; i++) begin
      sck0 = 1'b1; wait_clks(6);
      sck0 = 1'b0; wait_clks(6);
    end
    check("miso_mid_frame", miso0, 1'b0);
    #3 rst_n = 1'b0;
    #1 check("miso_async_reset", miso0, 1'b1);
    mq0.delete(); mq1.delete();
    ovf_m[0] = 1'b0; ovf_m[1] = 1'b0; und_m[0] = 1'b0; und_m[1] = 1'b0;
    wait_clks(3);
    rst_n = 1'b1; cs0 = 1'b1;
    wait_clks(8);
    check_flags(0);
    do_frame(0, 16, 1'b0, '0);
    check_flags(0);

    // Randomised traffic on both instances.
    for (int it = 0; it < 16; it++) begin
      inst = $urandom_range(0, 1);
      np = $urandom_range(0, 5);
      for (int k = 0; k < np; k++) push(inst, 16'($urandom));
      check_flags(inst);
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 15) : 16;
        do_frame(inst, nb, 1'b0, '0);
        check_flags(inst);
      end
      if ($urandom_range(0, 3) == 0) begin
        clear_all();
        check_flags(inst);
      end
    end

    wait_clks(10);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("frame_done_count%0d", i), done_seen[i], done_exp[i]);
      check($sformatf("frame_abort_count%0d", i), abort_seen[i], abort_exp[i]);
    end
    check("exp_q0_drained", exp_q0.size(), 0);
    check("exp_q1_drained", exp_q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
